// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, oversampling constants and small helpers.
// Used by both the receive path and the transmitter.
package uart_pkg;

  localparam int unsigned OVERSAMPLE      = 16;
  localparam int unsigned FRAME_DATA_BITS = 8;
  localparam int unsigned SCNT_W          = $clog2(OVERSAMPLE);
  localparam int unsigned BCNT_W          = $clog2(FRAME_DATA_BITS);

  localparam logic [SCNT_W-1:0] MID_SAMPLE  = SCNT_W'(7);
  localparam logic [SCNT_W-1:0] LAST_SAMPLE = SCNT_W'(OVERSAMPLE - 1);
  localparam logic [BCNT_W-1:0] LAST_BIT    = BCNT_W'(FRAME_DATA_BITS - 1);

  localparam int unsigned STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_START  = 3'd1;
  localparam logic [STATE_W-1:0] ST_DATA   = 3'd2;
  localparam logic [STATE_W-1:0] ST_PARITY = 3'd3;
  localparam logic [STATE_W-1:0] ST_STOP   = 3'd4;

  typedef struct packed {
    logic [FRAME_DATA_BITS-1:0] data;
    logic                       perr;
    logic                       ferr;
  } rx_result_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// 16x oversampling tick generator: free-running divider, tick_o high for one clk
// every CLK_HZ/(BAUD*16) cycles.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 9600
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int unsigned DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick_o = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// RS232 receiver: 16x oversampled, LSB-first, optional even parity, one stop bit.
// Build option UART_RX_MAJORITY_EN: 2-of-3 majority vote per bit decision.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 9600
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  input  logic       psel_i,
  output logic [7:0] data_o,
  output logic       rdy_o,
  output logic       perr_o,
  output logic       ferr_o,
  output logic       busy_o
);

  logic                       tick;
  logic                       sync1, sync2, prev;
  logic [STATE_W-1:0]         state;
  logic [SCNT_W-1:0]          scnt;
  logic [BCNT_W-1:0]          bitcnt;
  logic [FRAME_DATA_BITS-1:0] shreg;
  logic                       psel_l, pbit, stop_bit, fin;
  logic                       busy, rdy;
  rx_result_t                 res;
  logic                       smp;

  uart_baud_tick #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) u_tick (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .tick_o(tick)
  );

`ifdef UART_RX_MAJORITY_EN
  // Vote over the two previous tick samples plus the current one, so the
  // decision still happens at the same count as the single-sample build.
  logic [1:0] hist;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hist <= '1;
    end else if (tick) begin
      hist <= {hist[0], sync2};
    end
  end

  assign smp = maj3(hist[1], hist[0], sync2);
`else
  assign smp = sync2;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      prev     <= 1'b1;
      state    <= ST_IDLE;
      scnt     <= '0;
      bitcnt   <= '0;
      shreg    <= '0;
      psel_l   <= 1'b0;
      pbit     <= 1'b0;
      stop_bit <= 1'b1;
      fin      <= 1'b0;
      busy     <= 1'b0;
      rdy      <= 1'b0;
      res      <= '0;
    end else begin
      sync1 <= rx_i;
      sync2 <= sync1;
      prev  <= sync2;
      rdy   <= 1'b0;
      fin   <= 1'b0;

      // Results publish one clk after the stop decision; the FSM is already
      // back in IDLE then, so a start edge in this cycle is not lost.
      if (fin) begin
        res.data <= shreg;
        res.perr <= psel_l & (^{shreg, pbit});
        res.ferr <= ~stop_bit;
        rdy      <= 1'b1;
        busy     <= 1'b0;
      end

      if (tick) begin
        scnt <= scnt + SCNT_W'(1);
      end

      case (state)
        ST_IDLE: begin
          if (prev && !sync2) begin
            state <= ST_START;
            scnt  <= '0;
          end
        end
        ST_START: begin
          if (tick && scnt == MID_SAMPLE) begin
            scnt <= '0;
            if (!smp) begin
              state  <= ST_DATA;
              bitcnt <= '0;
              busy   <= 1'b1;
              psel_l <= psel_i;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (tick && scnt == LAST_SAMPLE) begin
            shreg <= {smp, shreg[FRAME_DATA_BITS-1:1]};
            if (bitcnt == LAST_BIT) begin
              state <= psel_l ? ST_PARITY : ST_STOP;
            end else begin
              bitcnt <= bitcnt + BCNT_W'(1);
            end
          end
        end
        ST_PARITY: begin
          if (tick && scnt == LAST_SAMPLE) begin
            pbit  <= smp;
            state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (tick && scnt == LAST_SAMPLE) begin
            stop_bit <= smp;
            fin      <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign data_o = res.data;
  assign perr_o = res.perr;
  assign ferr_o = res.ferr;
  assign rdy_o  = rdy;
  assign busy_o = busy;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at CLK_HZ=1.6 MHz, BAUD=10k (160 clk per bit).
// Expected frames are queued when sent and compared by the rdy_o monitor.
module tb_uart_rx;

  localparam int BIT = 160;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       psel = 1'b0;
  logic [7:0] data;
  logic       rdy, perr, ferr, busy;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;
  int   rdy_cnt = 0;
  int   cyc = 0;
  int   rdy_cyc = 0;
  logic rdy_prev = 1'b0;

  uart_rx #(
    .CLK_HZ(1_600_000),
    .BAUD  (10_000)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .rx_i  (rx),
    .psel_i(psel),
    .data_o(data),
    .rdy_o (rdy),
    .perr_o(perr),
    .ferr_o(ferr),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every rdy_o pulse must match the oldest queued frame.
  always @(negedge clk) begin
    if (!rst) begin
      if (rdy) begin
        rdy_cnt = rdy_cnt + 1;
        rdy_cyc = cyc;
        checks = checks + 1;
        if (rdy_prev !== 1'b0) begin
          failures = failures + 1;
          $display("FAIL rdy_pulse_width: rdy_o high two cycles in a row");
        end
        checks = checks + 1;
        if (exp_q.size() == 0) begin
          failures = failures + 1;
          $display("FAIL unexpected_rdy: got data=%h perr=%b ferr=%b, no frame expected", data, perr, ferr);
        end else begin
          e = exp_q.pop_front();
          if (data !== e.data || perr !== e.perr || ferr !== e.ferr) begin
            failures = failures + 1;
            $display("FAIL frame: got data=%h perr=%b ferr=%b, expected data=%h perr=%b ferr=%b",
                     data, perr, ferr, e.data, e.perr, e.ferr);
          end
        end
      end
      rdy_prev = rdy;
    end else begin
      rdy_prev = 1'b0;
    end
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_en, input logic pb, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (par_en) send_bit(pb);
    send_bit(stop);
  endtask

  task automatic test_reset;
    repeat (5) @(negedge clk);
    checks = checks + 1;
    if ({data, rdy, perr, ferr, busy} !== 12'h000) begin
      failures = failures + 1;
      $display("FAIL reset_outputs: got data=%h rdy=%b perr=%b ferr=%b busy=%b, expected all zero",
               data, rdy, perr, ferr, busy);
    end
    rst = 1'b0;
    repeat (2 * BIT) @(negedge clk);
    checks = checks + 1;
    if (rdy_cnt !== 0 || busy !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL idle_after_reset: rdy_cnt=%0d busy=%b, expected 0 0", rdy_cnt, busy);
    end
  endtask

  task automatic test_basic;
    int c0, t0, lat;
    psel = 1'b0;
    exp_q.push_back('{8'hA5, 1'b0, 1'b0});
    c0 = rdy_cnt;
    t0 = cyc;
    fork
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
      begin
        repeat (3 * BIT) @(negedge clk);
        checks = checks + 1;
        if (busy !== 1'b1) begin
          failures = failures + 1;
          $display("FAIL busy_mid_frame: got %b, expected 1", busy);
        end
      end
    join
    send_bit(1'b1);
    checks = checks + 1;
    if (rdy_cnt !== c0 + 1) begin
      failures = failures + 1;
      $display("FAIL basic_rdy_count: got %0d, expected %0d", rdy_cnt - c0, 1);
    end
    lat = rdy_cyc - t0;
    checks = checks + 1;
    if (lat < 1510 || lat > 1530) begin
      failures = failures + 1;
      $display("FAIL latency: got %0d clk, expected 1510..1530", lat);
    end
    checks = checks + 1;
    if (busy !== 1'b0 || data !== 8'hA5) begin
      failures = failures + 1;
      $display("FAIL basic_hold: got busy=%b data=%h, expected 0 a5", busy, data);
    end
  endtask

  task automatic test_parity;
    int c0;
    c0 = rdy_cnt;
    psel = 1'b1;
    exp_q.push_back('{8'h37, 1'b0, 1'b0});
    fork
      send_frame(8'h37, 1'b1, 1'b1, 1'b1);
      begin
        repeat (2 * BIT) @(negedge clk);
        psel = 1'b0;
      end
    join
    send_bit(1'b1);
    psel = 1'b1;
    exp_q.push_back('{8'h37, 1'b1, 1'b0});
    send_frame(8'h37, 1'b1, 1'b0, 1'b1);
    send_bit(1'b1);
    psel = 1'b0;
    checks = checks + 1;
    if (rdy_cnt !== c0 + 2) begin
      failures = failures + 1;
      $display("FAIL parity_rdy_count: got %0d, expected %0d", rdy_cnt - c0, 2);
    end
  endtask

  task automatic test_break;
    int c0;
    c0 = rdy_cnt;
    exp_q.push_back('{8'h3C, 1'b0, 1'b1});
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (20) send_bit(1'b0);
    checks = checks + 1;
    if (rdy_cnt !== c0 + 1 || busy !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL break_no_refire: got rdy=%0d busy=%b, expected rdy=1 busy=0", rdy_cnt - c0, busy);
    end
    checks = checks + 1;
    if (data !== 8'h3C || ferr !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL break_hold: got data=%h ferr=%b, expected 3c 1", data, ferr);
    end
    send_bit(1'b1);
    send_bit(1'b1);
    exp_q.push_back('{8'h5A, 1'b0, 1'b0});
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    send_bit(1'b1);
    checks = checks + 1;
    if (rdy_cnt !== c0 + 2) begin
      failures = failures + 1;
      $display("FAIL break_recover: got %0d frames, expected %0d", rdy_cnt - c0, 2);
    end
  endtask

  task automatic test_glitch;
    int   c0;
    logic seen;
    c0 = rdy_cnt;
    seen = 1'b0;
    rx = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    rx = 1'b1;
    repeat (2 * BIT) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    checks = checks + 1;
    if (seen !== 1'b0 || rdy_cnt !== c0 || data !== 8'h5A) begin
      failures = failures + 1;
      $display("FAIL glitch: got busy_seen=%b rdy=%0d data=%h, expected 0 0 5a", seen, rdy_cnt - c0, data);
    end
  endtask

  task automatic test_back_to_back;
    int c0;
    c0 = rdy_cnt;
    exp_q.push_back('{8'h00, 1'b0, 1'b0});
    exp_q.push_back('{8'hFF, 1'b0, 1'b0});
    exp_q.push_back('{8'h55, 1'b0, 1'b0});
    send_frame(8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
    send_frame(8'h55, 1'b0, 1'b0, 1'b1);
    send_bit(1'b1);
    checks = checks + 1;
    if (rdy_cnt !== c0 + 3 || exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL back_to_back: got %0d frames, %0d still pending, expected 3 0", rdy_cnt - c0, exp_q.size());
    end
  endtask

  task automatic test_reset_midframe;
    int c0;
    c0 = rdy_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    rx = 1'b0;
    repeat (BIT / 2) @(negedge clk);
    checks = checks + 1;
    if (busy !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL busy_before_reset: got %b, expected 1", busy);
    end
    rst = 1'b1;
    #1;
    checks = checks + 1;
    if ({data, rdy, perr, ferr, busy} !== 12'h000) begin
      failures = failures + 1;
      $display("FAIL reset_midframe: got data=%h rdy=%b perr=%b ferr=%b busy=%b, expected all zero",
               data, rdy, perr, ferr, busy);
    end
    rx = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    repeat (2 * BIT) @(negedge clk);
    exp_q.push_back('{8'h81, 1'b0, 1'b0});
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    send_bit(1'b1);
    checks = checks + 1;
    if (rdy_cnt !== c0 + 1) begin
      failures = failures + 1;
      $display("FAIL after_reset_frame: got %0d frames, expected %0d", rdy_cnt - c0, 1);
    end
  endtask

`ifdef UART_RX_MAJORITY_EN
  task automatic test_majority;
    int         c0;
    logic [9:0] bits;
    c0 = rdy_cnt;
    bits = {1'b1, 8'hA5, 1'b0};
    exp_q.push_back('{8'hA5, 1'b0, 1'b0});
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (BIT / 2) @(negedge clk);
      rx = ~bits[i];
      @(negedge clk);
      rx = bits[i];
      repeat (BIT / 2 - 1) @(negedge clk);
    end
    send_bit(1'b1);
    send_bit(1'b1);
    checks = checks + 1;
    if (rdy_cnt !== c0 + 1) begin
      failures = failures + 1;
      $display("FAIL majority_frames: got %0d, expected %0d", rdy_cnt - c0, 1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_break();
    test_glitch();
    test_back_to_back();
    test_reset_midframe();
`ifdef UART_RX_MAJORITY_EN
    test_majority();
`endif
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL missing_frames: %0d expected frames never reported, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
